dnn_mem_req_arbiter: RTL

Shares the single DNN memory-controller request port (read and write channels, as exposed by the DNN-to-AMI bridge wrapper) between one read requester (stream loader) and NUM_PU per-PU output writers. Each cycle it either holds or forwards one transaction. It alternates fairly between reads and writes and round-robins among PUs. It caps outstanding writes and routes each wr_done back to the PU that issued the write. It sits directly between the accelerator's memory-access logic and the bridge's rd_*/wr_* ports.

---
 rtl/dnn_mem_req_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dnn_mem_req_arbiter.sv
// dnn_mem_req_arbiter
//
// Shares one downstream memory request port (separate read and write
// channels) between a single read requester and NUM_PU write requesters.
// Each transaction is granted from IDLE and then held in an ISSUE state
// until the downstream side accepts it. Reads and writes alternate when
// both are pending. PUs are served round-robin. The number of accepted but
// uncompleted writes is capped at MAX_WR_OUT, and each wr_done is routed
// back to the PU that issued the oldest outstanding write.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   up_rd_req/addr/size/ack    upstream read requester (ack = 1-cycle pulse)
//   pu_wr_req/addr/size/ack    per-PU write requesters, packed by PU index
//   pu_wr_done                 one-hot completion pulse per PU
//   rd_req/ready/addr/req_size downstream read channel
//   wr_req/ready/pu_id/addr/req_size  downstream write channel
//   wr_done                    downstream completion of the oldest write
//   wr_outstanding             writes accepted downstream, not yet done
//   err_underflow              sticky: wr_done seen with nothing outstanding
module dnn_mem_req_arbiter #(
    parameter int NUM_PU        = 2,
    parameter int ADDR_W        = 32,
    parameter int TX_SIZE_WIDTH = 10,
    parameter int PU_ID_W       = $clog2(NUM_PU) + 1,
    parameter int MAX_WR_OUT    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              up_rd_req,
    input  logic [ADDR_W-1:0]                 up_rd_addr,
    input  logic [TX_SIZE_WIDTH-1:0]          up_rd_size,
    output logic                              up_rd_ack,
    input  logic [NUM_PU-1:0]                 pu_wr_req,
    input  logic [NUM_PU*ADDR_W-1:0]          pu_wr_addr,
    input  logic [NUM_PU*TX_SIZE_WIDTH-1:0]   pu_wr_size,
    output logic [NUM_PU-1:0]                 pu_wr_ack,
    output logic [NUM_PU-1:0]                 pu_wr_done,
    output logic                              rd_req,
    input  logic                              rd_ready,
    output logic [ADDR_W-1:0]                 rd_addr,
    output logic [TX_SIZE_WIDTH-1:0]          rd_req_size,
    output logic                              wr_req,
    input  logic                              wr_ready,
    output logic [PU_ID_W-1:0]                wr_pu_id,
    output logic [ADDR_W-1:0]                 wr_addr,
    output logic [TX_SIZE_WIDTH-1:0]          wr_req_size,
    input  logic                              wr_done,
    output logic [$clog2(MAX_WR_OUT):0]       wr_outstanding,
    output logic                              err_underflow
);
    localparam int CNT_W = $clog2(MAX_WR_OUT) + 1;
    localparam int PTR_W = (MAX_WR_OUT > 1) ? $clog2(MAX_WR_OUT) : 1;
    localparam int RR_W  = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_ISSUE} state_t;
    localparam logic CLS_RD = 1'b0;
    localparam logic CLS_WR = 1'b1;

    state_t                   state_q, state_d;
    logic                     last_class_q, last_class_d;
    logic [RR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                     up_rd_ack_q, up_rd_ack_d;
    logic [NUM_PU-1:0]        pu_wr_ack_q, pu_wr_ack_d;
    logic [NUM_PU-1:0]        pu_wr_done_q, pu_wr_done_d;
    logic                     rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [TX_SIZE_WIDTH-1:0] rd_size_q, rd_size_d;
    logic                     wr_req_q, wr_req_d;
    logic [PU_ID_W-1:0]       wr_pu_id_q, wr_pu_id_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [TX_SIZE_WIDTH-1:0] wr_size_q, wr_size_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [PTR_W-1:0]         fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [PTR_W-1:0]         fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [PU_ID_W-1:0]       fifo_mem [MAX_WR_OUT];
    logic [PU_ID_W-1:0]       fifo_head;

    logic [ADDR_W-1:0]        pu_addr_arr [NUM_PU];
    logic [TX_SIZE_WIDTH-1:0] pu_size_arr [NUM_PU];
    logic [RR_W:0]            rr_idx;
    logic [RR_W-1:0]          pu_sel;
    logic                     pu_found;
    logic                     rd_elig, wr_elig, grant_rd, grant_wr;
    logic                     push, pop;

    // Unpack the per-PU buses into arrays indexed by PU.
    for (genvar gi = 0; gi < NUM_PU; gi++) begin : g_unpack
        assign pu_addr_arr[gi] = pu_wr_addr[gi*ADDR_W +: ADDR_W];
        assign pu_size_arr[gi] = pu_wr_size[gi*TX_SIZE_WIDTH +: TX_SIZE_WIDTH];
    end

    // Round-robin search starting just above the last granted PU.
    always_comb begin
        pu_found = 1'b0;
        pu_sel   = '0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_PU; k++) begin
            rr_idx = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
            if (rr_idx >= (RR_W+1)'(NUM_PU)) begin
                rr_idx = rr_idx - (RR_W+1)'(NUM_PU);
            end
            if (!pu_found && pu_wr_req[rr_idx[RR_W-1:0]]) begin
                pu_found = 1'b1;
                pu_sel   = rr_idx[RR_W-1:0];
            end
        end
    end

    // A completion arriving this cycle frees a slot for the write being granted.
    assign rd_elig  = up_rd_req;
    assign wr_elig  = pu_found && ((cnt_q < CNT_W'(MAX_WR_OUT)) || wr_done);
    assign grant_rd = rd_elig && (!wr_elig || (last_class_q == CLS_WR));
    assign grant_wr = wr_elig && !grant_rd;

    // Arbitration FSM and downstream output registers.
    always_comb begin
        state_d      = state_q;
        last_class_d = last_class_q;
        rr_ptr_d     = rr_ptr_q;
        up_rd_ack_d  = 1'b0;
        pu_wr_ack_d  = '0;
        rd_req_d     = rd_req_q;
        rd_addr_d    = rd_addr_q;
        rd_size_d    = rd_size_q;
        wr_req_d     = wr_req_q;
        wr_pu_id_d   = wr_pu_id_q;
        wr_addr_d    = wr_addr_q;
        wr_size_d    = wr_size_q;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    rd_req_d     = 1'b1;
                    rd_addr_d    = up_rd_addr;
                    rd_size_d    = up_rd_size;
                    up_rd_ack_d  = 1'b1;
                    last_class_d = CLS_RD;
                    state_d      = RD_ISSUE;
                end else if (grant_wr) begin
                    wr_req_d            = 1'b1;
                    wr_pu_id_d          = PU_ID_W'(pu_sel);
                    wr_addr_d           = pu_addr_arr[pu_sel];
                    wr_size_d           = pu_size_arr[pu_sel];
                    pu_wr_ack_d[pu_sel] = 1'b1;
                    last_class_d        = CLS_WR;
                    rr_ptr_d            = pu_sel;
                    state_d             = WR_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (rd_ready) begin
                    rd_req_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            WR_ISSUE: begin
                if (wr_ready) begin
                    wr_req_d = 1'b0;
                    push     = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding-write tracking: id FIFO plus counter. A completion with
    // nothing outstanding is dropped and flagged rather than popping.
    assign pop       = wr_done && (cnt_q != '0);
    assign fifo_head = fifo_mem[fifo_rd_ptr_q];

    always_comb begin
        cnt_d         = cnt_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        err_d         = err_q | (wr_done && (cnt_q == '0));
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (push) begin
            fifo_wr_ptr_d = (fifo_wr_ptr_q == PTR_W'(MAX_WR_OUT-1)) ? '0 : fifo_wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            fifo_rd_ptr_d = (fifo_rd_ptr_q == PTR_W'(MAX_WR_OUT-1)) ? '0 : fifo_rd_ptr_q + PTR_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_PU; gi++) begin : g_done
        assign pu_wr_done_d[gi] = pop && (fifo_head == PU_ID_W'(gi));
    end

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr_q] <= wr_pu_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_class_q  <= CLS_WR;
            rr_ptr_q      <= RR_W'(NUM_PU-1);
            up_rd_ack_q   <= 1'b0;
            pu_wr_ack_q   <= '0;
            pu_wr_done_q  <= '0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            rd_size_q     <= '0;
            wr_req_q      <= 1'b0;
            wr_pu_id_q    <= '0;
            wr_addr_q     <= '0;
            wr_size_q     <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
        end else begin
            state_q       <= state_d;
            last_class_q  <= last_class_d;
            rr_ptr_q      <= rr_ptr_d;
            up_rd_ack_q   <= up_rd_ack_d;
            pu_wr_ack_q   <= pu_wr_ack_d;
            pu_wr_done_q  <= pu_wr_done_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            rd_size_q     <= rd_size_d;
            wr_req_q      <= wr_req_d;
            wr_pu_id_q    <= wr_pu_id_d;
            wr_addr_q     <= wr_addr_d;
            wr_size_q     <= wr_size_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
        end
    end

    assign up_rd_ack      = up_rd_ack_q;
    assign pu_wr_ack      = pu_wr_ack_q;
    assign pu_wr_done     = pu_wr_done_q;
    assign rd_req         = rd_req_q;
    assign rd_addr        = rd_addr_q;
    assign rd_req_size    = rd_size_q;
    assign wr_req         = wr_req_q;
    assign wr_pu_id       = wr_pu_id_q;
    assign wr_addr        = wr_addr_q;
    assign wr_req_size    = wr_size_q;
    assign wr_outstanding = cnt_q;
    assign err_underflow  = err_q;

endmodule
